// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data RAM.
// Port 0 is the core data port; port 1 is a secondary master such as a loader, DMA or debug.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RAM_AW    = 10,
    parameter int MAX_BURST = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [RAM_AW-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              ram_wread,
    input  logic [DATA_W-1:0] ram_salida,
    output logic [1:0]        dbg_owner
);

    // Handshake: a requester raises mN_req and holds req/we/addr/wdata stable
    // until mN_gnt is high in the same cycle. The access completes on that
    // rising edge. A granted read returns mN_rvalid with data one cycle later.

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    owner_t           owner_q;
    logic [CNT_W-1:0] burst_cnt_q;
    logic             last_q;    // 0 = port 0 served last, 1 = port 1
    logic             rvalid_q;
    logic             rsel_q;

    owner_t           gnt_owner;
    logic             any_gnt;
    logic             rd_gnt;

    // Grants are forced low during reset so the RAM sees no enables.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (RESET_N) begin
            if (m0_req && !m1_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req && !m0_req) begin
                m1_gnt = 1'b1;
            end else if (m0_req && m1_req) begin
                if (owner_q == OWN_P0 && burst_cnt_q < MAX_CNT) begin
                    m0_gnt = 1'b1;
                end else if (owner_q == OWN_P1 && burst_cnt_q < MAX_CNT) begin
                    m1_gnt = 1'b1;
                end else if (last_q) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
            end
        end
    end

    assign any_gnt   = m0_gnt | m1_gnt;
    assign gnt_owner = m1_gnt ? OWN_P1 : OWN_P0;
    assign rd_gnt    = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);

    always_comb begin
        ram_address = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        ram_wread   = 1'b0;
        if (m0_gnt) begin
            ram_address = m0_addr[RAM_AW+1:2];
            ram_data    = m0_wdata;
            ram_wren    = m0_we;
            ram_wread   = ~m0_we;
        end else if (m1_gnt) begin
            ram_address = m1_addr[RAM_AW+1:2];
            ram_data    = m1_wdata;
            ram_wren    = m1_we;
            ram_wread   = ~m1_we;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            owner_q     <= OWN_NONE;
            burst_cnt_q <= '0;
            last_q      <= 1'b1;
            rvalid_q    <= 1'b0;
            rsel_q      <= 1'b0;
        end else begin
            rvalid_q <= rd_gnt;
            if (rd_gnt) begin
                rsel_q <= m1_gnt;
            end
            if (any_gnt) begin
                owner_q <= gnt_owner;
                last_q  <= m1_gnt;
                // Count saturates so a lone requester can stream indefinitely.
                if (owner_q == gnt_owner) begin
                    burst_cnt_q <= (burst_cnt_q < MAX_CNT) ? burst_cnt_q + CNT_W'(1) : MAX_CNT;
                end else begin
                    burst_cnt_q <= CNT_W'(1);
                end
            end else begin
                owner_q     <= OWN_NONE;
                burst_cnt_q <= '0;
            end
        end
    end

    assign m0_rvalid = rvalid_q & ~rsel_q;
    assign m1_rvalid = rvalid_q & rsel_q;
    assign m0_rdata  = m0_rvalid ? ram_salida : '0;
    assign m1_rdata  = m1_rvalid ? ram_salida : '0;
    assign dbg_owner = owner_q;

    // The upper and lower address bits are outside the RAM word range.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[ADDR_W-1:RAM_AW+2], m0_addr[1:0],
                                m1_addr[ADDR_W-1:RAM_AW+2], m1_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a table of per-cycle vectors checked against a RAM model,
// followed by hand-written reset, burst-fairness and streaming sequences.
module tb_dmem_arbiter;

    logic        CLK;
    logic        RESET_N;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [9:0]  ram_address;
    logic [31:0] ram_data, ram_salida;
    logic        ram_wren, ram_wread;
    logic [1:0]  dbg_owner;

    int n_vec  = 0;
    int n_fail = 0;

    dmem_arbiter dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_wread(ram_wread), .ram_salida(ram_salida), .dbg_owner(dbg_owner)
    );

    // Clock and reset.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // RAM model: registered read data, preloaded with A000_0000 + word index.
    logic [31:0] mem [1024];
    bit          preloaded = 1'b0;
    always @(posedge CLK) begin
        if (!preloaded) begin
            for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
            preloaded = 1'b1;
        end
        if (ram_wren) mem[ram_address] = ram_data;
        if (ram_wread) ram_salida <= mem[ram_address];
    end

    typedef struct {
        logic        m0_req, m0_we;
        logic [31:0] m0_addr, m0_wdata;
        logic        m1_req, m1_we;
        logic [31:0] m1_addr, m1_wdata;
        logic        e_g0, e_g1;
        logic [9:0]  e_addr;
        logic [31:0] e_data;
        logic        e_wren, e_wread;
        logic        e_rv0;
        logic [31:0] e_rd0;
        logic        e_rv1;
        logic [31:0] e_rd1;
    } vec_t;

    localparam logic        Y = 1'b1;
    localparam logic        N = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic apply_vec(input int i);
        @(negedge CLK);
        m0_req = vecs[i].m0_req; m0_we = vecs[i].m0_we;
        m0_addr = vecs[i].m0_addr; m0_wdata = vecs[i].m0_wdata;
        m1_req = vecs[i].m1_req; m1_we = vecs[i].m1_we;
        m1_addr = vecs[i].m1_addr; m1_wdata = vecs[i].m1_wdata;
        #1;
        chk($sformatf("v%0d m0_gnt", i), 32'(m0_gnt), 32'(vecs[i].e_g0));
        chk($sformatf("v%0d m1_gnt", i), 32'(m1_gnt), 32'(vecs[i].e_g1));
        chk($sformatf("v%0d ram_address", i), 32'(ram_address), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d ram_data", i), ram_data, vecs[i].e_data);
        chk($sformatf("v%0d ram_wren", i), 32'(ram_wren), 32'(vecs[i].e_wren));
        chk($sformatf("v%0d ram_wread", i), 32'(ram_wread), 32'(vecs[i].e_wread));
        chk($sformatf("v%0d m0_rvalid", i), 32'(m0_rvalid), 32'(vecs[i].e_rv0));
        chk($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].e_rd0);
        chk($sformatf("v%0d m1_rvalid", i), 32'(m1_rvalid), 32'(vecs[i].e_rv1));
        chk($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].e_rd1);
    endtask

    initial begin
        int g0_cnt;
        int p1_wait;
        bit p1_done;
        bit exp_p1;

        //             m0 req/we/addr/wdata         m1 req/we/addr/wdata               g0 g1 addr   data           wren wread rv0 rd0           rv1 rd1
        vecs[0]  = '{Y, N, 32'h10, Z,            N, N, Z, Z,                         Y, N, 10'd4, Z,            N, Y, N, Z,            N, Z};
        vecs[1]  = '{N, N, Z, Z,                 N, N, Z, Z,                         N, N, 10'd0, Z,            N, N, Y, 32'hA0000004, N, Z};
        vecs[2]  = '{N, N, Z, Z,                 Y, Y, 32'h20, 32'hDEADBEEF,         N, Y, 10'd8, 32'hDEADBEEF, Y, N, N, Z,            N, Z};
        vecs[3]  = '{Y, N, 32'h20, Z,            N, N, Z, Z,                         Y, N, 10'd8, Z,            N, Y, N, Z,            N, Z};
        vecs[4]  = '{N, N, Z, Z,                 N, N, Z, Z,                         N, N, 10'd0, Z,            N, N, Y, 32'hDEADBEEF, N, Z};
        vecs[5]  = '{Y, N, 32'h14, Z,            N, N, Z, Z,                         Y, N, 10'd5, Z,            N, Y, N, Z,            N, Z};
        vecs[6]  = '{N, N, Z, Z,                 Y, N, 32'h18, Z,                    N, Y, 10'd6, Z,            N, Y, Y, 32'hA0000005, N, Z};
        vecs[7]  = '{Y, N, 32'h1C, Z,            N, N, Z, Z,                         Y, N, 10'd7, Z,            N, Y, N, Z,            Y, 32'hA0000006};
        vecs[8]  = '{N, N, Z, Z,                 Y, N, 32'hFFFFF00F, Z,              N, Y, 10'd3, Z,            N, Y, Y, 32'hA0000007, N, Z};
        vecs[9]  = '{N, N, Z, Z,                 N, N, Z, Z,                         N, N, 10'd0, Z,            N, N, N, Z,            Y, 32'hA0000003};
        vecs[10] = '{Y, Y, 32'h0, 32'h55,        N, N, Z, Z,                         Y, N, 10'd0, 32'h55,       Y, N, N, Z,            N, Z};
        vecs[11] = '{Y, N, 32'h4, Z,             Y, N, 32'h8, Z,                     Y, N, 10'd1, Z,            N, Y, N, Z,            N, Z};
        vecs[12] = '{N, N, Z, Z,                 Y, N, Z, Z,                         N, Y, 10'd0, Z,            N, Y, Y, 32'hA0000001, N, Z};
        vecs[13] = '{N, N, Z, Z,                 N, N, Z, Z,                         N, N, 10'd0, Z,            N, N, N, Z,            Y, 32'h55};

        drive_idle();
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("reset m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("reset dbg_owner", 32'(dbg_owner), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        for (int i = 0; i < 14; i++) apply_vec(i);

        // Reset asserted while a read is in flight and another is requested.
        @(negedge CLK);
        drive_idle();
        m0_req = 1'b1; m0_addr = 32'h10;
        #1;
        chk("rst_mid m0_gnt before", 32'(m0_gnt), 32'd1);
        @(posedge CLK);
        #1;
        chk("rst_mid m0_rvalid before", 32'(m0_rvalid), 32'd1);
        RESET_N = 1'b0;
        #1;
        chk("rst_mid m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_mid m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_mid m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_mid ram_wread", 32'(ram_wread), 32'd0);
        chk("rst_mid ram_wren", 32'(ram_wren), 32'd0);
        chk("rst_mid dbg_owner", 32'(dbg_owner), 32'd0);
        drive_idle();
        @(negedge CLK);
        RESET_N = 1'b1;

        // Both ports request continuously from reset: P0 x4, P1 x4, P0 x4.
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
            m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h80;
            #1;
            exp_p1 = ((c / 4) % 2) == 1;
            chk($sformatf("burst c%0d m0_gnt", c), 32'(m0_gnt), 32'(!exp_p1));
            chk($sformatf("burst c%0d m1_gnt", c), 32'(m1_gnt), 32'(exp_p1));
        end
        @(negedge CLK);
        drive_idle();

        // P0 streams 10 reads; P1 joins at cycle 6 and must be served within 4 cycles.
        g0_cnt = 0; p1_wait = 0; p1_done = 1'b0;
        for (int c = 0; c < 30 && (g0_cnt < 10 || !p1_done); c++) begin
            @(negedge CLK);
            m0_req = (g0_cnt < 10); m0_we = 1'b0; m0_addr = 32'(g0_cnt * 4);
            m1_req = (c >= 6) && !p1_done; m1_we = 1'b0; m1_addr = 32'h100;
            #1;
            chk($sformatf("stream c%0d one-hot", c), 32'(m0_gnt & m1_gnt), 32'd0);
            if (c < 6) chk($sformatf("stream c%0d m0_gnt", c), 32'(m0_gnt), 32'd1);
            if (m0_gnt) g0_cnt++;
            if (m1_req) begin
                if (m1_gnt) begin
                    chk("stream p1 latency ok", 32'(p1_wait <= 4), 32'd1);
                    p1_done = 1'b1;
                end else begin
                    p1_wait++;
                end
            end
        end
        chk("stream p0 grants", 32'(g0_cnt), 32'd10);
        chk("stream p1 served", 32'(p1_done), 32'd1);
        @(negedge CLK);
        drive_idle();
        repeat (2) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
